seg7_capture: RTL and testbench
===============================

# seg7_capture

Monitor/receiver for the two-digit, common-cathode 7-segment bus driven by the display blocks: samples `sm_cs1_n`, `sm_cs2_n` and `sm_db[6:0]`, waits until the bus is stable, and decodes each enabled digit back to its 4-bit hex value. It is used on boards where the display bus is looped back or probed, and in benches, to recover the displayed number as data. The bus is treated as asynchronous to `clk`.

## Interface
- `STABLE_CYCLES`, 16, number of consecutive equal synchronized samples required before a commit; legal range 2..65535.
- `CNT_W`, 16, width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

- `clk`  in  1  system clock, 50 MHz; all state on the rising edge.
- `rst`  in  1  reset, asynchronous assert, active-high; released synchronously to `clk` externally.
- `sm_cs1_n`  in  1  digit 1 select, low = enabled.
- `sm_cs2_n`  in  1  digit 2 select, low = enabled.
- `sm_db`  in  7  segment pattern, bit0 = segment a … bit6 = segment g, high = lit.
- `dig1_val`  out  4  last committed hex value of digit 1.
- `dig2_val`  out  4  last committed hex value of digit 2.
- `dig1_ok`  out  1  digit 1 holds a valid decoded value.
- `dig2_ok`  out  1  digit 2 holds a valid decoded value.
- `dig1_blank`  out  1  digit 1 last seen dark (pattern 7'h00).
- `dig2_blank`  out  1  digit 2 last seen dark.
- `upd`  out  1  one-cycle pulse: a committed digit's value/ok/blank changed.
- `err`  out  1  one-cycle pulse: a commit saw an enabled digit with an undecodable pattern.

## Operation
- Two-flop synchronizer on the 9-bit word {cs1_n, cs2_n, db} → `word_s`; one further register → `word_q`.
- Stability counter `cnt`: cleared when `word_s != word_q`, otherwise incremented, saturating at STABLE_CYCLES-1.
- FSM, two states:
  - SETTLE (reset state): a commit occurs when `word_s == word_q` and `cnt == STABLE_CYCLES-1`, then the FSM goes to LOCKED.
  - LOCKED: no commits. Any `word_s != word_q` returns the FSM to SETTLE and clears `cnt`.
- Decode of `sm_db`:
  - The 16 hex codes 3f 06 5b 4f 66 6d 7d 07 7f 6f 77 7c 39 5e 79 71 → values 0..F, ok=1, blank=0.
  - 7'h00 → ok=0, blank=1; value holds its previous committed value.
  - Any other pattern → ok=0, blank=0, value holds; `err` pulses.
- Commit, per digit:
  - A digit whose cs_n is low loads the decode result.
  - A digit whose cs_n is high keeps its previous value, ok and blank.
  - Both selects low: both digits load the same result.
  - Both selects high: nothing loads; `upd` and `err` stay low.
- `upd` pulses in the commit cycle only if at least one digit's {val, ok, blank} differs from its previous value. Re-committing identical data gives no pulse.
- `err` and `upd` may pulse in the same cycle.

## Timing
- Reset values:
  - FSM = SETTLE, `cnt` = 0, synchronizer and `word_q` = 9'h180 (both selects deasserted, db = 0).
  - All `digN_val` = 0, `digN_ok` = 0, `digN_blank` = 0, `upd` = 0, `err` = 0.
- Latency: with the input changed before edge 1 and then held, the commit updates outputs at rising edge STABLE_CYCLES+3.
- Glitches shorter than STABLE_CYCLES+1 cycles never produce a commit.
- Outputs are registered and hold between commits.
- Asserting `rst` mid-count or in LOCKED returns every output to its reset value immediately, with no pulse.
- `cnt` saturates; holding the bus static indefinitely produces exactly one commit.

## Structure
- Package `seg7_pkg`:
  - The 16 segment constants and `SEG_BLANK = 7'h00`.
  - The decode result type {ok, blank, val[3:0]}.
  - The default STABLE_CYCLES value.
- Sub-module `seg7_decode`: purely combinational, maps `sm_db` to the decode result; instantiated once on `word_s`'s db field.
- Top level `seg7_capture`: synchronizer, stability counter, FSM, per-digit output registers, pulse generation.

## Test plan
- Reset, then bus = {0, 0, 7'h3f} held → at edge STABLE_CYCLES+3, `dig1_val` = `dig2_val` = 0, both ok = 1, `upd` pulses once; held for 1000 more cycles → no further pulses.
- cs1_n=0, cs2_n=1, db = 7'h5b, then cs1_n=1, cs2_n=0, db = 7'h71 → `dig1_val` = 2, then `dig2_val` = F with `dig1_val` still 2; one `upd` per commit.
- db = 7'h00 on digit 1 → `dig1_blank` = 1, `dig1_ok` = 0, `dig1_val` retains 2; db = 7'h12 → `err` pulses, `dig1_ok` = 0, `dig1_blank` = 0.
- 5-cycle glitch to 7'h06 with STABLE_CYCLES=16 → no commit, outputs unchanged; 20-cycle hold → commit, `dig1_val` = 1.
- Same pattern re-presented after a 20-cycle deselect (both cs_n high) → no `upd`, no `err`.
- `rst` asserted at `cnt` = 8 → all outputs 0 immediately; after release the full STABLE_CYCLES+3 latency applies again.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment bus capture block.
// Contents: segment codes for hex 0..F and blank, the decode result type,
// the FSM state type and the default stability window.
package seg7_pkg;

   // Segment patterns, bit0 = a ... bit6 = g, high = lit
   localparam logic [6:0] SEG_0     = 7'h3f;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5b;
   localparam logic [6:0] SEG_3     = 7'h4f;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6d;
   localparam logic [6:0] SEG_6     = 7'h7d;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7f;
   localparam logic [6:0] SEG_9     = 7'h6f;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h7c;
   localparam logic [6:0] SEG_C     = 7'h39;
   localparam logic [6:0] SEG_D     = 7'h5e;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_F     = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam int unsigned STABLE_CYCLES_DEF = 16;

   typedef struct packed {
      logic       ok;
      logic       blank;
      logic [3:0] val;
   } seg7_dec_t;

   typedef enum logic {
      StSettle,
      StLocked
   } seg7_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern decoder.
// Ports: i_db  - segment pattern (bit0 = a ... bit6 = g)
//        o_dec - {ok, blank, val}; val is 0 whenever ok is low
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] i_db,
   output seg7_dec_t  o_dec
);

   always_comb begin
      o_dec = '{ok: 1'b1, blank: 1'b0, val: 4'h0};
      case (i_db)
         SEG_0:     o_dec.val = 4'h0;
         SEG_1:     o_dec.val = 4'h1;
         SEG_2:     o_dec.val = 4'h2;
         SEG_3:     o_dec.val = 4'h3;
         SEG_4:     o_dec.val = 4'h4;
         SEG_5:     o_dec.val = 4'h5;
         SEG_6:     o_dec.val = 4'h6;
         SEG_7:     o_dec.val = 4'h7;
         SEG_8:     o_dec.val = 4'h8;
         SEG_9:     o_dec.val = 4'h9;
         SEG_A:     o_dec.val = 4'ha;
         SEG_B:     o_dec.val = 4'hb;
         SEG_C:     o_dec.val = 4'hc;
         SEG_D:     o_dec.val = 4'hd;
         SEG_E:     o_dec.val = 4'he;
         SEG_F:     o_dec.val = 4'hf;
         SEG_BLANK: o_dec = '{ok: 1'b0, blank: 1'b1, val: 4'h0};
         default:   o_dec = '{ok: 1'b0, blank: 1'b0, val: 4'h0};
      endcase
   end

endmodule

// File: rtl/seg7_capture.sv
// Receiver for the two-digit common-cathode 7-segment bus. Synchronizes the
// bus, waits for it to be stable for STABLE_CYCLES samples, then decodes the
// enabled digit(s) once and holds the result until the bus changes again.
// Ports: clk, rst (async, active-high)
//        sm_cs1_n, sm_cs2_n, sm_db  - probed display bus (asynchronous)
//        digN_val/ok/blank          - last committed state of digit N
//        upd                        - pulse, a committed digit changed
//        err                        - pulse, commit saw an undecodable pattern
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int unsigned CNT_W         = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sm_cs1_n,
   input  logic       sm_cs2_n,
   input  logic [6:0] sm_db,
   output logic [3:0] dig1_val,
   output logic [3:0] dig2_val,
   output logic       dig1_ok,
   output logic       dig2_ok,
   output logic       dig1_blank,
   output logic       dig2_blank,
   output logic       upd,
   output logic       err
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
   // Idle bus: both selects deasserted, all segments dark
   localparam logic [8:0]       WORD_RST = 9'h180;

   logic [8:0]       r_sync1;
   logic [8:0]       r_word_s;
   logic [8:0]       r_word_q;
   logic [CNT_W-1:0] r_cnt;
   seg7_state_e      r_state;
   seg7_state_e      w_state_d;
   seg7_dec_t        r_dig1;
   seg7_dec_t        r_dig2;
   seg7_dec_t        w_dig1_d;
   seg7_dec_t        w_dig2_d;
   seg7_dec_t        w_dec;
   logic             r_upd;
   logic             r_err;
   logic             w_equal;
   logic             w_commit;
   logic             w_cs1_en;
   logic             w_cs2_en;
   logic             w_upd;
   logic             w_err;

   assign w_equal  = (r_word_s == r_word_q);
   assign w_cs1_en = ~r_word_s[8];
   assign w_cs2_en = ~r_word_s[7];

   seg7_decode u_decode (
      .i_db  (r_word_s[6:0]),
      .o_dec (w_dec)
   );

   always_comb begin
      w_state_d = r_state;
      w_commit  = 1'b0;
      case (r_state)
         StSettle: begin
            if (w_equal && (r_cnt == CNT_MAX)) begin
               w_commit  = 1'b1;
               w_state_d = StLocked;
            end
         end
         StLocked: begin
            if (!w_equal) begin
               w_state_d = StSettle;
            end
         end
         default: w_state_d = StSettle;
      endcase
   end

   // Blank and undecodable patterns keep the last good value
   always_comb begin
      w_dig1_d = r_dig1;
      w_dig2_d = r_dig2;
      if (w_commit && w_cs1_en) begin
         w_dig1_d.ok    = w_dec.ok;
         w_dig1_d.blank = w_dec.blank;
         if (w_dec.ok) begin
            w_dig1_d.val = w_dec.val;
         end
      end
      if (w_commit && w_cs2_en) begin
         w_dig2_d.ok    = w_dec.ok;
         w_dig2_d.blank = w_dec.blank;
         if (w_dec.ok) begin
            w_dig2_d.val = w_dec.val;
         end
      end
      w_upd = w_commit && ((w_dig1_d != r_dig1) || (w_dig2_d != r_dig2));
      w_err = w_commit && (w_cs1_en || w_cs2_en) && !w_dec.ok && !w_dec.blank;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1  <= WORD_RST;
         r_word_s <= WORD_RST;
         r_word_q <= WORD_RST;
         r_cnt    <= '0;
         r_state  <= StSettle;
         r_dig1   <= '0;
         r_dig2   <= '0;
         r_upd    <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_sync1  <= {sm_cs1_n, sm_cs2_n, sm_db};
         r_word_s <= r_sync1;
         r_word_q <= r_word_s;
         if (!w_equal) begin
            r_cnt <= '0;
         end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_state  <= w_state_d;
         r_dig1   <= w_dig1_d;
         r_dig2   <= w_dig2_d;
         r_upd    <= w_upd;
         r_err    <= w_err;
      end
   end

   assign dig1_val   = r_dig1.val;
   assign dig2_val   = r_dig2.val;
   assign dig1_ok    = r_dig1.ok;
   assign dig2_ok    = r_dig2.ok;
   assign dig1_blank = r_dig1.blank;
   assign dig2_blank = r_dig2.blank;
   assign upd        = r_upd;
   assign err        = r_err;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed self-checking bench for seg7_capture with STABLE_CYCLES = 16.
module tb_seg7_capture;

   logic       clk;
   logic       rst;
   logic       sm_cs1_n;
   logic       sm_cs2_n;
   logic [6:0] sm_db;
   logic [3:0] dig1_val;
   logic [3:0] dig2_val;
   logic       dig1_ok;
   logic       dig2_ok;
   logic       dig1_blank;
   logic       dig2_blank;
   logic       upd;
   logic       err;

   int checks   = 0;
   int failures = 0;
   int n_upd    = 0;
   int n_err    = 0;
   int base_upd;
   int base_err;

   seg7_capture #(
      .STABLE_CYCLES (16),
      .CNT_W         (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sm_cs1_n   (sm_cs1_n),
      .sm_cs2_n   (sm_cs2_n),
      .sm_db      (sm_db),
      .dig1_val   (dig1_val),
      .dig2_val   (dig2_val),
      .dig1_ok    (dig1_ok),
      .dig2_ok    (dig2_ok),
      .dig1_blank (dig1_blank),
      .dig2_blank (dig2_blank),
      .upd        (upd),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         if (upd) n_upd <= n_upd + 1;
         if (err) n_err <= n_err + 1;
      end
   end

   // {dig1_val, dig2_val, dig1_ok, dig2_ok, dig1_blank, dig2_blank}
   function automatic logic [11:0] snap();
      return {dig1_val, dig2_val, dig1_ok, dig2_ok, dig1_blank, dig2_blank};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Leaves time at 1 ns after the n-th following rising edge
   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic cs1_n, input logic cs2_n, input logic [6:0] db);
      sm_cs1_n = cs1_n;
      sm_cs2_n = cs2_n;
      sm_db    = db;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b1, 1'b1, 7'h00);
      wait_cyc(3);
      chk("reset_outputs", {20'h0, snap()}, 32'h0);
      chk("reset_pulses", {30'h0, upd, err}, 32'h0);
      rst = 1'b0;
      wait_cyc(30);
      chk("idle_no_upd", n_upd, 0);
      chk("idle_outputs", {20'h0, snap()}, 32'h0);

      // Both digits show 0; commit lands on edge 19
      base_upd = n_upd;
      drive(1'b0, 1'b0, 7'h3f);
      wait_cyc(18);
      chk("t1_before_commit", {20'h0, snap()}, 32'h0);
      wait_cyc(1);
      chk("t1_commit", {20'h0, snap()}, {20'h0, 4'h0, 4'h0, 4'b1100});
      chk("t1_upd_pulse", {31'h0, upd}, 32'h1);
      wait_cyc(1000);
      chk("t1_single_upd", n_upd - base_upd, 1);

      // Per-digit loading
      base_upd = n_upd;
      drive(1'b0, 1'b1, 7'h5b);
      wait_cyc(19);
      chk("t2_dig1_2", {20'h0, snap()}, {20'h0, 4'h2, 4'h0, 4'b1100});
      drive(1'b1, 1'b0, 7'h71);
      wait_cyc(19);
      chk("t2_dig2_f", {20'h0, snap()}, {20'h0, 4'h2, 4'hf, 4'b1100});
      wait_cyc(5);
      chk("t2_upd_count", n_upd - base_upd, 2);

      // Blank then undecodable on digit 1
      base_upd = n_upd;
      base_err = n_err;
      drive(1'b0, 1'b1, 7'h00);
      wait_cyc(19);
      chk("t3_blank", {20'h0, snap()}, {20'h0, 4'h2, 4'hf, 4'b0110});
      drive(1'b0, 1'b1, 7'h12);
      wait_cyc(19);
      chk("t3_err_pulse", {31'h0, err}, 32'h1);
      chk("t3_bad", {20'h0, snap()}, {20'h0, 4'h2, 4'hf, 4'b0100});
      wait_cyc(5);
      chk("t3_err_count", n_err - base_err, 1);
      chk("t3_upd_count", n_upd - base_upd, 2);

      // Glitch filtering
      drive(1'b0, 1'b1, 7'h3f);
      wait_cyc(25);
      chk("t4_dig1_0", {20'h0, snap()}, {20'h0, 4'h0, 4'hf, 4'b1100});
      base_upd = n_upd;
      drive(1'b0, 1'b1, 7'h06);
      wait_cyc(5);
      drive(1'b0, 1'b1, 7'h3f);
      wait_cyc(40);
      chk("t4_glitch5_hold", {20'h0, snap()}, {20'h0, 4'h0, 4'hf, 4'b1100});
      chk("t4_glitch5_upd", n_upd - base_upd, 0);
      drive(1'b0, 1'b1, 7'h07);
      wait_cyc(16);
      drive(1'b0, 1'b1, 7'h3f);
      wait_cyc(40);
      chk("t4_glitch16_upd", n_upd - base_upd, 0);
      drive(1'b0, 1'b1, 7'h07);
      wait_cyc(17);
      drive(1'b0, 1'b1, 7'h3f);
      wait_cyc(40);
      chk("t4_glitch17_upd", n_upd - base_upd, 2);
      drive(1'b0, 1'b1, 7'h06);
      wait_cyc(20);
      chk("t4_dig1_1", {20'h0, snap()}, {20'h0, 4'h1, 4'hf, 4'b1100});

      // Deselect and re-present identical data
      base_upd = n_upd;
      base_err = n_err;
      drive(1'b1, 1'b1, 7'h06);
      wait_cyc(20);
      drive(1'b0, 1'b1, 7'h06);
      wait_cyc(25);
      chk("t5_same_no_upd", n_upd - base_upd, 0);
      chk("t5_same_no_err", n_err - base_err, 0);
      drive(1'b1, 1'b1, 7'h12);
      wait_cyc(25);
      chk("t5_desel_bad_no_err", n_err - base_err, 0);
      chk("t5_hold", {20'h0, snap()}, {20'h0, 4'h1, 4'hf, 4'b1100});

      // Reset mid-count (cnt = 8 after edge 11)
      drive(1'b0, 1'b0, 7'h4f);
      wait_cyc(11);
      rst = 1'b1;
      #1;
      chk("t6_rst_outputs", {20'h0, snap()}, 32'h0);
      chk("t6_rst_pulses", {30'h0, upd, err}, 32'h0);
      wait_cyc(2);
      rst = 1'b0;
      base_upd = n_upd;
      wait_cyc(18);
      chk("t6_before_commit", {20'h0, snap()}, 32'h0);
      wait_cyc(1);
      chk("t6_commit", {20'h0, snap()}, {20'h0, 4'h3, 4'h3, 4'b1100});
      chk("t6_upd_pulse", {31'h0, upd}, 32'h1);
      wait_cyc(5);
      chk("t6_upd_count", n_upd - base_upd, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
